// File: rtl/riscv_pkg.sv
// Shared bus widths, CPU bus payload and responder state encoding.
package riscv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned BUS_W  = XLEN;

    typedef logic [BUS_W-1:0] word_t;

    // One CPU bus access as seen by the responder on a clock edge
    typedef struct packed {
        logic  we;
        word_t addr;
        word_t data;
    } cpu_req_t;

    typedef enum logic {
        INIT  = 1'b0,
        SERVE = 1'b1
    } resp_state_e;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, DEPTH_WORDS x BUS_W, write-first, one-cycle read.
module mem_array
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  word_t         wdata,
    output word_t         rdata
);

    word_t mem [DEPTH_WORDS];

    // Write-first port: a write returns the new data on the read port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-mapped word responder: FSM, address decode, sticky error and
// power-up clear sweep in front of a mem_array.
// Optional macro MEM_RESPONDER_CLEAR_EN: zero the whole array after reset
// (DEPTH_WORDS cycles); without it INIT lasts a single cycle.
module mem_responder
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ready_o,
    output logic        err_o
);

    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    cpu_req_t    req;
    resp_state_e state_q, state_d;
    logic        err_q, err_d;
    logic        rd_valid_q, rd_valid_d;
`ifdef MEM_RESPONDER_CLEAR_EN
    logic [AW-1:0] cnt_q, cnt_d;
`endif

    word_t         offset;
    logic [AW-1:0] idx;
    logic          in_range;
    logic          aligned;
    logic          acc_ok;

    logic          ram_we;
    logic [AW-1:0] ram_addr;
    word_t         ram_wdata;
    word_t         ram_rdata;

    assign req = '{we: we_i, addr: addr_i, data: data_i};

    // Range and alignment decode relative to BASE_ADDR
    always_comb begin
        offset   = req.addr - BASE_ADDR;
        in_range = (req.addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
        aligned  = (req.addr[1:0] == 2'b00);
        acc_ok   = in_range && aligned;
        idx      = offset[AW+1:2];
    end

    // State, sticky error, read-valid and sweep counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= INIT;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
`ifdef MEM_RESPONDER_CLEAR_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
`ifdef MEM_RESPONDER_CLEAR_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    // Next state, RAM port control and error update
    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        rd_valid_d = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = idx;
        ram_wdata  = req.data;
`ifdef MEM_RESPONDER_CLEAR_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            INIT: begin
`ifdef MEM_RESPONDER_CLEAR_EN
                ram_we    = 1'b1;
                ram_addr  = cnt_q;
                ram_wdata = '0;
                if (cnt_q == AW'(DEPTH_WORDS - 1)) begin
                    state_d = SERVE;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
`else
                state_d = SERVE;
`endif
            end
            SERVE: begin
                if (acc_ok) begin
                    ram_we     = req.we;
                    rd_valid_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = INIT;
        endcase
    end

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_mem_array (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Read data only passes for a valid served access; zero otherwise
    assign data_o  = rd_valid_q ? ram_rdata : '0;
    assign ready_o = (state_q == SERVE);
    assign err_o   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder (DEPTH_WORDS=16, base 0).
module tb_mem_responder;

    localparam int unsigned DEPTH = 16;
`ifdef MEM_RESPONDER_CLEAR_EN
    localparam int INIT_CYC = 16;
    localparam bit CLEARS   = 1'b1;
`else
    localparam int INIT_CYC = 1;
    localparam bit CLEARS   = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        ready_o;
    logic        err_o;

    int checks   = 0;
    int failures = 0;

    // Reference model: word array, which words hold a defined value, sticky error
    logic [31:0] model_mem [DEPTH];
    bit          known     [DEPTH];
    bit          model_err;

    mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (32'h0000_0000)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .data_i  (data_i),
        .data_o  (data_o),
        .ready_o (ready_o),
        .err_o   (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one access, let one rising edge take it, sample 1 time unit later
    task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] data);
        we_i   = we;
        addr_i = addr;
        data_i = data;
        @(posedge clk);
        #1;
    endtask

    // Expected data_o after an access in SERVE, updating the model
    function automatic void predict(input logic we, input logic [31:0] addr,
                                    input logic [31:0] data,
                                    output logic [31:0] exp, output bit exp_known);
        int unsigned i;
        if (addr < 32'(DEPTH * 4) && addr[1:0] == 2'b00) begin
            i = addr >> 2;
            if (we) begin
                model_mem[i] = data;
                known[i]     = 1'b1;
            end
            exp       = model_mem[i];
            exp_known = known[i];
        end else begin
            exp       = 32'h0;
            exp_known = 1'b1;
            model_err = 1'b1;
        end
    endfunction

    // State of the model after a completed INIT phase
    function automatic void model_after_init();
        for (int i = 0; i < int'(DEPTH); i++) begin
            model_mem[i] = 32'h0;
            known[i]     = CLEARS;
        end
        model_err = 1'b0;
    endfunction

    task automatic test_reset();
        int n;
        we_i   = 1'b0;
        addr_i = 32'h0;
        data_i = 32'h0;
        reset  = 1'b0;
        #1;
        checks++; if (data_o !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", data_o); end
        checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_o); end
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        n = 0;
        // Random junk on the bus during INIT must be ignored
        while (ready_o !== 1'b1 && n < 100) begin
            we_i   = 1'($urandom);
            addr_i = $urandom;
            data_i = $urandom;
            @(posedge clk);
            #1;
            n++;
            if (ready_o !== 1'b1) begin
                checks++; if (data_o !== 32'h0) begin failures++; $display("FAIL init_data cyc=%0d got=%h exp=0", n, data_o); end
                checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL init_err cyc=%0d got=%b exp=0", n, err_o); end
            end
        end
        we_i   = 1'b0;
        addr_i = 32'h0;
        checks++; if (n !== INIT_CYC) begin failures++; $display("FAIL init_len got=%0d exp=%0d", n, INIT_CYC); end
        model_after_init();
    endtask

    task automatic test_init_zero();
        logic [31:0] exp;
        bit          k;
        for (int i = 0; i < int'(DEPTH); i++) begin
            predict(1'b0, 32'(i * 4), 32'h0, exp, k);
            drive(1'b0, 32'(i * 4), 32'h0);
            if (k) begin
                checks++; if (data_o !== exp) begin failures++; $display("FAIL init_zero addr=%h got=%h exp=%h", i * 4, data_o, exp); end
            end
            checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL init_zero_ready got=%b exp=1", ready_o); end
        end
    endtask

    task automatic test_write_read();
        logic [31:0] exp;
        bit          k;
        predict(1'b1, 32'h08, 32'hDEAD_BEEF, exp, k);
        drive(1'b1, 32'h08, 32'hDEAD_BEEF);
        checks++; if (data_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_08_write got=%h exp=deadbeef", data_o); end
        predict(1'b0, 32'h08, 32'h0, exp, k);
        drive(1'b0, 32'h08, 32'h1234_5678);
        checks++; if (data_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_08_read got=%h exp=deadbeef", data_o); end
        predict(1'b1, 32'h0C, 32'hCAFE_F00D, exp, k);
        drive(1'b1, 32'h0C, 32'hCAFE_F00D);
        predict(1'b0, 32'h0C, 32'h0, exp, k);
        drive(1'b0, 32'h0C, 32'h0);
        checks++; if (data_o !== exp) begin failures++; $display("FAIL wr_0c_read got=%h exp=%h", data_o, exp); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        bit          k;
        logic [31:0] seq_we   [4] = '{32'h1, 32'h1, 32'h0, 32'h0};
        logic [31:0] seq_addr [4] = '{32'h0, 32'h4, 32'h0, 32'h4};
        logic [31:0] seq_dat  [4] = '{32'h11, 32'h22, 32'h0, 32'h0};
        logic [31:0] seq_exp  [4] = '{32'h11, 32'h22, 32'h11, 32'h22};
        for (int i = 0; i < 4; i++) begin
            predict(seq_we[i][0], seq_addr[i], seq_dat[i], exp, k);
            drive(seq_we[i][0], seq_addr[i], seq_dat[i]);
            checks++; if (data_o !== seq_exp[i]) begin failures++; $display("FAIL b2b step=%0d got=%h exp=%h", i, data_o, seq_exp[i]); end
        end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL b2b_err got=%b exp=0", err_o); end
    endtask

    task automatic test_random();
        logic [31:0] exp;
        bit          k;
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        for (int i = 0; i < 200; i++) begin
            we = 1'($urandom);
            a  = 32'($urandom_range(0, DEPTH - 1)) << 2;
            d  = $urandom;
            predict(we, a, d, exp, k);
            drive(we, a, d);
            if (k) begin
                checks++; if (data_o !== exp) begin failures++; $display("FAIL rand_data i=%0d addr=%h got=%h exp=%h", i, a, data_o, exp); end
            end
            checks++; if (err_o !== model_err) begin failures++; $display("FAIL rand_err i=%0d got=%b exp=%b", i, err_o, model_err); end
        end
    endtask

    task automatic test_errors();
        logic [31:0] exp;
        bit          k;
        logic [31:0] a;
        predict(1'b1, 32'h40, 32'h55, exp, k);
        drive(1'b1, 32'h40, 32'h55);
        checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL err_oor got=%b exp=1", err_o); end
        checks++; if (data_o !== 32'h0) begin failures++; $display("FAIL err_oor_data got=%h exp=0", data_o); end
        predict(1'b0, 32'h06, 32'h0, exp, k);
        drive(1'b0, 32'h06, 32'h0);
        checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL err_mis got=%b exp=1", err_o); end
        checks++; if (data_o !== 32'h0) begin failures++; $display("FAIL err_mis_data got=%h exp=0", data_o); end
        // A few more random bad accesses, writes must be dropped
        for (int i = 0; i < 8; i++) begin
            a = (i % 2 == 0) ? (32'h40 + ($urandom & 32'hFFFF_FFC0)) : (32'($urandom_range(0, 63)) | 32'h1);
            predict(1'b1, a, $urandom, exp, k);
            drive(1'b1, a, 32'hFFFF_FFFF);
            checks++; if (data_o !== 32'h0) begin failures++; $display("FAIL err_rand_data addr=%h got=%h exp=0", a, data_o); end
        end
        // Contents unchanged and error stays set
        for (int i = 0; i < int'(DEPTH); i++) begin
            predict(1'b0, 32'(i * 4), 32'h0, exp, k);
            drive(1'b0, 32'(i * 4), 32'h0);
            if (k) begin
                checks++; if (data_o !== exp) begin failures++; $display("FAIL err_mem addr=%h got=%h exp=%h", i * 4, data_o, exp); end
            end
            checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL err_sticky i=%0d got=%b exp=1", i, err_o); end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int          n;
        logic [31:0] exp;
        bit          k;
        we_i   = 1'b0;
        addr_i = 32'h0;
        reset  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        repeat (7) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++; if (data_o !== 32'h0) begin failures++; $display("FAIL mid_reset_data got=%h exp=0", data_o); end
        checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL mid_reset_ready got=%b exp=0", ready_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL mid_reset_err got=%b exp=0", err_o); end
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        n = 0;
        while (ready_o !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (n !== INIT_CYC) begin failures++; $display("FAIL mid_init_len got=%0d exp=%0d", n, INIT_CYC); end
        model_after_init();
        for (int i = 0; i < int'(DEPTH); i++) begin
            predict(1'b0, 32'(i * 4), 32'h0, exp, k);
            drive(1'b0, 32'(i * 4), 32'h0);
            if (k) begin
                checks++; if (data_o !== exp) begin failures++; $display("FAIL mid_zero addr=%h got=%h exp=%h", i * 4, data_o, exp); end
            end
        end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL mid_err got=%b exp=0", err_o); end
    endtask

    initial begin
        test_reset();
        test_init_zero();
        test_write_read();
        test_back_to_back();
        test_random();
        test_errors();
        test_reset_mid_sweep();
        test_write_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
